// File: rtl/data_port_if.sv
// data_port_if: core data-memory port, initiator (master) to responder (slave).
interface data_port_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0] data_wdata;
  logic [1:0] data_size;
  logic data_we;
  logic data_req;
  logic [31:0] data_rdata;
  logic data_ack;
  modport master (output data_addr, data_wdata, data_size, data_we, data_req, input data_rdata, data_ack);
  modport slave (input data_addr, data_wdata, data_size, data_we, data_req, output data_rdata, data_ack);
endinterface

// File: rtl/data_port_responder.sv
// data_port_responder: big-endian byte-array data-port target with programmable wait states.
module data_port_responder #(
  parameter int MEM_SIZE_BYTES = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  data_port_if.slave bus,
  output logic err_sticky,
  output logic [15:0] txn_count
);
  localparam int LW = $clog2(MEM_SIZE_BYTES);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [7:0] mem [MEM_SIZE_BYTES];
  logic [ADDR_WIDTH-1:0] a_l, ea;
  logic [31:0] wd_l, lj, rd;
  logic [1:0] sz_l, sz;
  logic we_l;
  logic [3:0] cnt;
  logic [2:0] nb;
  logic [ADDR_WIDTH:0] last;
  logic oor, enter;
  logic [7:0] b [4];
  // In IDLE the live request fields are used so zero-wait responses see them directly
  always_comb begin
    ea = state == IDLE ? bus.data_addr : a_l;
    sz = state == IDLE ? bus.data_size : sz_l;
    nb = sz == 2'd0 ? 3'd1 : sz == 2'd1 ? 3'd2 : 3'd4;
    last = {1'b0, ea} + (ADDR_WIDTH+1)'(nb) - (ADDR_WIDTH+1)'(1);
    oor = last >= (ADDR_WIDTH+1)'(MEM_SIZE_BYTES);
    for (int k = 0; k < 4; k++) b[k] = mem[LW'(ea + ADDR_WIDTH'(k))];
    rd = sz == 2'd0 ? {24'd0, b[0]} : sz == 2'd1 ? {16'd0, b[0], b[1]} : {b[0], b[1], b[2], b[3]};
    lj = sz_l == 2'd0 ? {wd_l[7:0], 24'd0} : sz_l == 2'd1 ? {wd_l[15:0], 16'd0} : wd_l;
    enter = (state == IDLE && bus.data_req && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
  end
  assign bus.data_ack = state == RESP;
  always_ff @(posedge clk)
    if (!rst && state == RESP && we_l && !oor)
      for (int k = 0; k < 4; k++)
        if (k < int'(nb)) mem[LW'(a_l + ADDR_WIDTH'(k))] <= lj[31-8*k -: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.data_rdata <= '0;
      err_sticky <= 1'b0;
      txn_count <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.data_req) begin
          a_l <= bus.data_addr;
          wd_l <= bus.data_wdata;
          sz_l <= bus.data_size;
          we_l <= bus.data_we;
          cnt <= 4'(WAIT_CYCLES);
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= RESP;
      end else if (state == RESP) begin
        state <= IDLE;
        txn_count <= txn_count + 16'd1;
      end else state <= IDLE;
      if (enter) begin
        bus.data_rdata <= oor ? 32'd0 : rd;
        err_sticky <= err_sticky | oor;
      end
    end
  end
endmodule

// File: tb/tb_data_port_responder.sv
// tb_data_port_responder: directed table plus multi-cycle sequences for the data-port responder.
module tb_data_port_responder;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  data_port_if #(.ADDR_WIDTH(32)) b2 (), b0 ();
  logic err2, err0;
  logic [15:0] cnt2, cnt0;
  data_port_responder #(.MEM_SIZE_BYTES(4096), .ADDR_WIDTH(32), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2), .err_sticky(err2), .txn_count(cnt2));
  data_port_responder #(.MEM_SIZE_BYTES(4096), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .err_sticky(err0), .txn_count(cnt0));
  typedef struct {
    logic we;
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  vec_t v [13];
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic txn2(input vec_t x, output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    b2.data_we = x.we;
    b2.data_size = x.size;
    b2.data_addr = x.addr;
    b2.data_wdata = x.wdata;
    b2.data_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!b2.data_ack && lat < 20);
    rd = b2.data_rdata;
    er = err2;
    @(negedge clk);
    b2.data_req = 1'b0;
  endtask
  task automatic single0(output logic ack);
    @(negedge clk);
    b0.data_we = 1'b0;
    b0.data_size = 2'd2;
    b0.data_addr = 32'h10;
    b0.data_req = 1'b1;
    @(posedge clk);
    #1;
    ack = b0.data_ack;
    @(negedge clk);
    b0.data_req = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat, pulses;
    logic [31:0] rd;
    logic er, a;
    v[0]  = '{1'b1, 2'd2, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b0, 2'd2, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b0, 2'd0, 32'h11,       32'h0,        32'h000000AD, 1'b0};
    v[3]  = '{1'b0, 2'd1, 32'h12,       32'h0,        32'h0000BEEF, 1'b0};
    v[4]  = '{1'b1, 2'd1, 32'h11,       32'h1234,     32'h0,        1'b0};
    v[5]  = '{1'b0, 2'd2, 32'h10,       32'h0,        32'hDE1234EF, 1'b0};
    v[6]  = '{1'b0, 2'd3, 32'h10,       32'h0,        32'hDE1234EF, 1'b0};
    v[7]  = '{1'b0, 2'd2, 32'hFFC,      32'h0,        32'h01020304, 1'b0};
    v[8]  = '{1'b1, 2'd2, 32'hFFE,      32'hAABBCCDD, 32'h0,        1'b1};
    v[9]  = '{1'b0, 2'd2, 32'hFFC,      32'h0,        32'h01020304, 1'b1};
    v[10] = '{1'b0, 2'd0, 32'hFFF,      32'h0,        32'h00000004, 1'b1};
    v[11] = '{1'b0, 2'd2, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
    v[12] = '{1'b0, 2'd1, 32'hFFF,      32'h0,        32'h0,        1'b1};
    b2.data_req = 0; b2.data_we = 0; b2.data_size = 0; b2.data_addr = 0; b2.data_wdata = 0;
    b0.data_req = 0; b0.data_we = 0; b0.data_size = 0; b0.data_addr = 0; b0.data_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      u2.mem[12'hFFC + i] = 8'(i + 1);
      u2.mem[12'h020 + i] = 8'h55;
    end
    u0.mem[12'h10] = 8'hCA; u0.mem[12'h11] = 8'hFE; u0.mem[12'h12] = 8'hBA; u0.mem[12'h13] = 8'hBE;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 32'(b2.data_ack), 32'd0);
    chk("reset_rdata", b2.data_rdata, 32'd0);
    chk("reset_err", 32'(err2), 32'd0);
    chk("reset_count", 32'(cnt2), 32'd0);
    chk("reset_count0", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      txn2(v[i], lat, rd, er);
      chk($sformatf("latency_%0d", i), 32'(lat), 32'd3);
      if (!v[i].we) chk($sformatf("rdata_%0d", i), rd, v[i].rdata);
      chk($sformatf("err_%0d", i), 32'(er), 32'(v[i].err));
    end
    chk("mem_10_13", {u2.mem[12'h10], u2.mem[12'h11], u2.mem[12'h12], u2.mem[12'h13]}, 32'hDE1234EF);
    @(posedge clk);
    #1;
    chk("count_table", 32'(cnt2), 32'd13);
    // reset while the store sits in WAIT must discard it
    @(negedge clk);
    b2.data_we = 1'b1; b2.data_size = 2'd2; b2.data_addr = 32'h20; b2.data_wdata = 32'h11223344; b2.data_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1; b2.data_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      pulses += int'(b2.data_ack);
    end
    chk("rst_no_ack", 32'(pulses), 32'd0);
    chk("rst_mem_20", {u2.mem[12'h20], u2.mem[12'h21], u2.mem[12'h22], u2.mem[12'h23]}, 32'h55555555);
    chk("rst_count", 32'(cnt2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    txn2('{1'b0, 2'd2, 32'h20, 32'h0, 32'h0, 1'b0}, lat, rd, er);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", rd, 32'h55555555);
    @(posedge clk);
    #1;
    chk("post_rst_count", 32'(cnt2), 32'd1);
    // zero-wait back-to-back with req held high
    @(negedge clk);
    b0.data_we = 1'b0; b0.data_size = 2'd2; b0.data_addr = 32'h10; b0.data_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b_ack_%0d", i), 32'(b0.data_ack), 32'(i % 2 == 0));
    end
    chk("b2b_rdata", b0.data_rdata, 32'hCAFEBABE);
    @(negedge clk);
    b0.data_req = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_ack_end", 32'(b0.data_ack), 32'd0);
    chk("b2b_count", 32'(cnt0), 32'd3);
    single0(a);
    pulses = int'(a);
    repeat (3) begin
      @(posedge clk);
      #1;
      pulses += int'(b0.data_ack);
    end
    chk("single_pulses", 32'(pulses), 32'd1);
    chk("single_count", 32'(cnt0), 32'd4);
    @(negedge clk);
    u0.txn_count = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      single0(a);
      chk($sformatf("wrap_ack_%0d", i), 32'(a), 32'd1);
    end
    chk("wrap_count", 32'(cnt0), 32'd1);
    chk("err0_clear", 32'(err0), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
